// File: rtl/stim_seq_chk.sv
// Table-driven stimulus sequencer and self-checker for the balance-platform top level.
// Plays programmed steps onto the DUT inputs, then scores wheel-speed / platform-angle behaviour.
module stim_seq_chk #(
  parameter  int DEPTH     = 16,
  parameter  int HOLD_W    = 20,
  parameter  int SPD_TOL   = 0,
  parameter  int THETA_TOL = 255,
  parameter  int TIMEOUT   = 1000000,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1,
  localparam int DW        = 78 + HOLD_W
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic [CW-1:0]      num_steps,
  input  logic               start,
  input  logic               abort,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic signed [15:0] theta_platform,
  output logic [11:0]        ld_cell_lft,
  output logic [11:0]        ld_cell_rght,
  output logic [11:0]        steerPot,
  output logic [11:0]        batt,
  output logic signed [15:0] rider_lean,
  output logic               OVR_I_lft,
  output logic               OVR_I_rght,
  output logic [7:0]         cmd,
  output logic               send_cmd,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      step_idx,
  output logic [CW-1:0]      pass_cnt,
  output logic [CW-1:0]      fail_cnt,
  output logic               err_vld,
  output logic [AW-1:0]      err_step
);

  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMD, S_HOLD, S_CHECK, S_SETTLE, S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    CHK_NONE = 3'd0, CHK_LEFT, CHK_RIGHT, CHK_STRAIGHT, CHK_THETA
  } chk_e;

  typedef struct packed {
    logic [HOLD_W-1:0] hold;
    logic [2:0]        chk_mode;
    logic              cmd_vld;
    logic [7:0]        cmd;
    logic              ovr_r;
    logic              ovr_l;
    logic [15:0]       lean;
    logic [11:0]       batt;
    logic [11:0]       steer;
    logic [11:0]       ld_rght;
    logic [11:0]       ld_lft;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            mem_q [DEPTH];
  entry_t            ent;

  logic [11:0]       ld_lft_q, ld_rght_q, steer_q, batt_q;
  logic [15:0]       lean_q;
  logic              ovr_l_q, ovr_r_q, send_cmd_q, busy_q, done_q, err_vld_q, cmd_cnt_q;
  logic [7:0]        cmd_q;
  logic [AW-1:0]     step_idx_q, err_step_q;
  logic [CW-1:0]     pass_cnt_q, fail_cnt_q, num_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [SW-1:0]     settle_cnt_q;

  logic signed [12:0] spd_diff;
  logic [12:0]        spd_abs;
  logic signed [16:0] theta_ext;
  logic [16:0]        theta_abs;
  logic               spd_ok, theta_ok, last_step, abort_run;
  logic               chk_pass, chk_fail, step_end;

  assign ent       = mem_q[step_idx_q];
  assign abort_run = abort && (state_q != S_IDLE);
  assign last_step = ({1'b0, step_idx_q} == (num_q - CW'(1)));

  // Widened by one bit so the extreme negative operands still yield a correct magnitude.
  assign spd_diff  = {lft_spd[11], lft_spd} - {rght_spd[11], rght_spd};
  assign spd_abs   = spd_diff[12] ? 13'(-spd_diff) : 13'(spd_diff);
  assign spd_ok    = (spd_abs <= 13'(SPD_TOL));
  assign theta_ext = {theta_platform[15], theta_platform};
  assign theta_abs = theta_ext[16] ? 17'(-theta_ext) : 17'(theta_ext);
  assign theta_ok  = (theta_abs <= 17'(THETA_TOL));

  // NOTE: memories carry no reset; the table is only ever read after being programmed.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) mem_q[wr_addr] <= entry_t'(wr_data);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    chk_pass = 1'b0;
    chk_fail = 1'b0;
    step_end = 1'b0;
    if (!abort_run) begin
      if (state_q == S_CHECK) begin
        step_end = 1'b1;
        case (chk_e'(ent.chk_mode))
          CHK_NONE:     ;
          CHK_LEFT:     begin chk_pass = (lft_spd < rght_spd);  chk_fail = (lft_spd >= rght_spd); end
          CHK_RIGHT:    begin chk_pass = (lft_spd > rght_spd);  chk_fail = (lft_spd <= rght_spd); end
          CHK_STRAIGHT: begin chk_pass = spd_ok;                chk_fail = !spd_ok;               end
          CHK_THETA:    step_end = 1'b0;
          default:      chk_fail = 1'b1;
        endcase
      end else if (state_q == S_SETTLE) begin
        if (theta_ok) begin
          chk_pass = 1'b1;
          step_end = 1'b1;
        end else if (settle_cnt_q == SW'(TIMEOUT - 1)) begin
          chk_fail = 1'b1;
          step_end = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_steps == '0) ? S_FINISH : S_LOAD;
      S_LOAD:   state_d = ent.cmd_vld ? S_CMD : S_HOLD;
      S_CMD:    if (cmd_cnt_q) state_d = S_HOLD;
      S_HOLD:   if (hold_cnt_q == HOLD_W'(1)) state_d = S_CHECK;
      S_CHECK:  if (chk_e'(ent.chk_mode) == CHK_THETA) state_d = S_SETTLE;
      S_SETTLE: ;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (step_end) state_d = last_step ? S_FINISH : S_LOAD;
    if (abort_run) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      ld_lft_q     <= '0;
      ld_rght_q    <= '0;
      steer_q      <= 12'h800;
      batt_q       <= '0;
      lean_q       <= '0;
      ovr_l_q      <= 1'b0;
      ovr_r_q      <= 1'b0;
      cmd_q        <= '0;
      send_cmd_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_idx_q   <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      err_vld_q    <= 1'b0;
      err_step_q   <= '0;
      num_q        <= '0;
      cmd_cnt_q    <= 1'b0;
      hold_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_run) begin
        busy_q     <= 1'b0;
        send_cmd_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_vld_q  <= 1'b0;
            step_idx_q <= '0;
            busy_q     <= 1'b1;
            num_q      <= (num_steps > CW'(DEPTH)) ? CW'(DEPTH) : num_steps;
          end
          S_LOAD: begin
            ld_lft_q   <= ent.ld_lft;
            ld_rght_q  <= ent.ld_rght;
            steer_q    <= ent.steer;
            batt_q     <= ent.batt;
            lean_q     <= ent.lean;
            ovr_l_q    <= ent.ovr_l;
            ovr_r_q    <= ent.ovr_r;
            cmd_q      <= ent.cmd;
            send_cmd_q <= ent.cmd_vld;
            cmd_cnt_q  <= 1'b0;
            hold_cnt_q <= (ent.hold == '0) ? HOLD_W'(1) : ent.hold;
          end
          S_CMD: begin
            cmd_cnt_q <= 1'b1;
            if (cmd_cnt_q) send_cmd_q <= 1'b0;
          end
          S_HOLD:   hold_cnt_q   <= hold_cnt_q - HOLD_W'(1);
          S_CHECK:  settle_cnt_q <= '0;
          S_SETTLE: settle_cnt_q <= settle_cnt_q + SW'(1);
          S_FINISH: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
        if (chk_pass) pass_cnt_q <= pass_cnt_q + CW'(1);
        if (chk_fail) begin
          fail_cnt_q <= fail_cnt_q + CW'(1);
          if (!err_vld_q) begin
            err_vld_q  <= 1'b1;
            err_step_q <= step_idx_q;
          end
        end
        if (step_end && !last_step) step_idx_q <= step_idx_q + AW'(1);
      end
    end
  end

  assign ld_cell_lft  = ld_lft_q;
  assign ld_cell_rght = ld_rght_q;
  assign steerPot     = steer_q;
  assign batt         = batt_q;
  assign rider_lean   = lean_q;
  assign OVR_I_lft    = ovr_l_q;
  assign OVR_I_rght   = ovr_r_q;
  assign cmd          = cmd_q;
  assign send_cmd     = send_cmd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign step_idx     = step_idx_q;
  assign pass_cnt     = pass_cnt_q;
  assign fail_cnt     = fail_cnt_q;
  assign err_vld      = err_vld_q;
  assign err_step     = err_step_q;

endmodule

// File: tb/tb_stim_seq_chk.sv
// Self-checking bench for stim_seq_chk: expected run results are queued at start and
// compared when the done pulse arrives; stimulus timing is checked cycle by cycle.
module tb_stim_seq_chk;

  localparam int DEPTH   = 16;
  localparam int HOLD_W  = 20;
  localparam int AW      = 4;
  localparam int CW      = 5;
  localparam int DW      = 78 + HOLD_W;
  localparam int TIMEOUT = 1000;

  localparam logic [2:0] C_NONE = 3'd0, C_LEFT = 3'd1, C_RIGHT = 3'd2, C_STRAIGHT = 3'd3, C_THETA = 3'd4;

  logic               clk = 1'b0;
  logic               RST_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [DW-1:0]      wr_data = '0;
  logic [CW-1:0]      num_steps = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic signed [11:0] lft_spd = '0;
  logic signed [11:0] rght_spd = '0;
  logic signed [15:0] theta_platform = '0;
  logic [11:0]        ld_cell_lft, ld_cell_rght, steerPot, batt;
  logic signed [15:0] rider_lean;
  logic               OVR_I_lft, OVR_I_rght, send_cmd, busy, done, err_vld;
  logic [7:0]         cmd;
  logic [AW-1:0]      step_idx, err_step;
  logic [CW-1:0]      pass_cnt, fail_cnt;

  stim_seq_chk #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .SPD_TOL(0), .THETA_TOL(255), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RST_n(RST_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_steps(num_steps), .start(start), .abort(abort),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .theta_platform(theta_platform),
    .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght), .steerPot(steerPot), .batt(batt),
    .rider_lean(rider_lean), .OVR_I_lft(OVR_I_lft), .OVR_I_rght(OVR_I_rght),
    .cmd(cmd), .send_cmd(send_cmd), .busy(busy), .done(done), .step_idx(step_idx),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_vld(err_vld), .err_step(err_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pass;
    int fail;
    int ev;
    int es;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   send_hi = 0;
  int   done_seen = 0;
  int   cmd_bad = 0;
  logic       cmd_watch_en = 1'b0;
  logic [7:0] cmd_watch = '0;

  always @(negedge clk) begin
    if (send_cmd) send_hi++;
    if (done) done_seen++;
    if (cmd_watch_en && busy && (cmd !== cmd_watch)) cmd_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_entry(input logic [11:0] steer, input logic [15:0] lean,
                                              input logic ovr_l, input logic ovr_r,
                                              input logic [7:0] cmdb, input logic cmdv,
                                              input logic [2:0] chk, input logic [19:0] hold);
    return {hold, chk, cmdv, cmdb, ovr_r, ovr_l, lean, 12'hA00, steer, 12'h222, 12'h111};
  endfunction

  task automatic write_step(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns one negedge after the edge that samples start.
  task automatic pulse_start(input logic [CW-1:0] n);
    @(negedge clk);
    num_steps = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_pass_cnt"}, 32'(pass_cnt), e.pass);
      check({tag, "_fail_cnt"}, 32'(fail_cnt), e.fail);
      check({tag, "_err_vld"},  32'(err_vld),  e.ev);
      if (e.ev != 0) check({tag, "_err_step"}, 32'(err_step), e.es);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_send, base_done, base_bad;

    #12;
    check("rst_steer",    32'(steerPot),    32'h800);
    check("rst_ld_lft",   32'(ld_cell_lft), 32'h0);
    check("rst_lean",     32'($unsigned(rider_lean)), 32'h0);
    check("rst_busy",     32'(busy),        32'h0);
    check("rst_send",     32'(send_cmd),    32'h0);
    check("rst_pass_cnt", 32'(pass_cnt),    32'h0);
    check("rst_err_vld",  32'(err_vld),     32'h0);
    @(negedge clk);
    RST_n = 1'b1;

    // 1: single LEFT step, field mapping and latency (LOAD + 100 HOLD + CHECK + FINISH)
    write_step(0, mk_entry(12'h600, 16'hFF38, 1'b1, 1'b0, 8'h00, 1'b0, C_LEFT, 20'd100));
    lft_spd = -12'sd50; rght_spd = 12'sd50;
    sb_q.push_back('{1, 0, 0, 0});
    pulse_start(1);
    check("t1_busy",      32'(busy),     32'd1);
    check("t1_steer_pre", 32'(steerPot), 32'h800);
    @(negedge clk);
    check("t1_steer",   32'(steerPot),     32'h600);
    check("t1_ld_lft",  32'(ld_cell_lft),  32'h111);
    check("t1_ld_rght", 32'(ld_cell_rght), 32'h222);
    check("t1_batt",    32'(batt),         32'hA00);
    check("t1_lean",    32'($unsigned(rider_lean)), 32'hFF38);
    check("t1_ovr_l",   32'(OVR_I_lft),    32'd1);
    check("t1_ovr_r",   32'(OVR_I_rght),   32'd0);
    wait_done("t1", 200, n);
    check("t1_latency", n, 102);

    // 2: RIGHT / STRAIGHT / LEFT with equal speeds; first failure latched at step 0
    write_step(0, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_RIGHT,    20'd5));
    write_step(1, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_STRAIGHT, 20'd5));
    write_step(2, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_LEFT,     20'd5));
    lft_spd = 12'sd200; rght_spd = 12'sd200;
    sb_q.push_back('{1, 2, 1, 0});
    pulse_start(3);
    wait_done("t2", 200, n);

    // 3: UART command: send_cmd high exactly two cycles, cmd stable to the end
    write_step(0, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h67, 1'b1, C_NONE, 20'd10));
    sb_q.push_back('{0, 0, 0, 0});
    base_send = send_hi;
    base_bad  = cmd_bad;
    pulse_start(1);
    check("t3_send_load", 32'(send_cmd), 32'd0);
    @(negedge clk);
    check("t3_send_c1", 32'(send_cmd), 32'd1);
    check("t3_cmd",     32'(cmd),      32'h67);
    cmd_watch = 8'h67; cmd_watch_en = 1'b1;
    @(negedge clk);
    check("t3_send_c2", 32'(send_cmd), 32'd1);
    @(negedge clk);
    check("t3_send_c3", 32'(send_cmd), 32'd0);
    wait_done("t3", 100, n);
    cmd_watch_en = 1'b0;
    check("t3_send_cycles", send_hi - base_send, 2);
    check("t3_cmd_stable",  cmd_bad - base_bad,  0);

    // 4a: theta settles after 500 cycles -> pass
    write_step(0, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_THETA, 20'd1));
    theta_platform = 16'sh0400;
    sb_q.push_back('{1, 0, 0, 0});
    base_done = done_seen;
    pulse_start(1);
    repeat (500) @(negedge clk);
    check("t4a_no_early_done", done_seen - base_done, 0);
    theta_platform = 16'sh0010;
    wait_done("t4a", 50, n);

    // 4b: theta pinned at -32768 -> fail after 1000 SETTLE cycles (LOAD+HOLD+CHECK+1000+FINISH)
    theta_platform = 16'sh8000;
    sb_q.push_back('{0, 1, 1, 0});
    pulse_start(1);
    wait_done("t4b", 1100, n);
    check("t4b_latency", n, 1004);
    theta_platform = 16'sh0000;

    // 5: abort in HOLD of step 1; start and wr_en while busy are ignored
    write_step(0, mk_entry(12'h700, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_LEFT, 20'd50));
    write_step(1, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_LEFT, 20'd50));
    write_step(2, mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_LEFT, 20'd50));
    lft_spd = -12'sd50; rght_spd = 12'sd50;
    pulse_start(3);
    n = 0;
    while ((step_idx != 1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_step1", 32'(step_idx), 32'd1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 0; wr_data = mk_entry(12'h123, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_RIGHT, 20'd1);
    @(negedge clk);
    wr_en = 1'b0;
    base_done = done_seen;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy",     32'(busy),     32'd0);
    check("t5_step_idx", 32'(step_idx), 32'd1);
    check("t5_pass_cnt", 32'(pass_cnt), 32'd1);
    check("t5_fail_cnt", 32'(fail_cnt), 32'd0);
    check("t5_send",     32'(send_cmd), 32'd0);
    repeat (20) @(negedge clk);
    check("t5_no_done", done_seen - base_done, 0);
    sb_q.push_back('{1, 0, 0, 0});
    pulse_start(1);
    @(negedge clk);
    check("t5_table_kept", 32'(steerPot), 32'h700);
    wait_done("t5b", 100, n);

    // 6: num_steps=0 goes straight to FINISH; done two edges after start is sampled-in
    sb_q.push_back('{0, 0, 0, 0});
    pulse_start(0);
    wait_done("t6", 10, n);
    check("t6_latency", n, 1);

    // 7: num_steps above DEPTH clamps to DEPTH; hold=0 behaves as 1 (3 cycles per step)
    for (int i = 0; i < DEPTH; i++)
      write_step(AW'(i), mk_entry(12'h800, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_LEFT, 20'd0));
    sb_q.push_back('{16, 0, 0, 0});
    pulse_start(5'd31);
    wait_done("t7", 200, n);
    check("t7_latency", n, 49);

    // 8: asynchronous reset mid-run
    write_step(0, mk_entry(12'h300, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, C_NONE, 20'd200));
    pulse_start(1);
    repeat (5) @(negedge clk);
    check("t8_steer_run", 32'(steerPot), 32'h300);
    check("t8_busy_run",  32'(busy),     32'd1);
    #2;
    RST_n = 1'b0;
    #1;
    check("t8_rst_steer", 32'(steerPot), 32'h800);
    check("t8_rst_busy",  32'(busy),     32'd0);
    check("t8_rst_pass",  32'(pass_cnt), 32'd0);
    check("t8_rst_ld",    32'(ld_cell_lft), 32'd0);
    @(negedge clk);
    RST_n = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
